// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter wide enough to hold the value WIDTH itself.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_cla_sub.sv
// N-bit subtractor a + ~b + 1 built from a ripple of 4-bit carry-lookahead cells.
// Carry-out of 0 means the subtraction borrowed (a < b).
module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1, c2, c3;

  assign g  = a_i & b_i;
  assign p  = a_i ^ b_i;
  assign c1 = g[0] | (p[0] & c_i);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c_i);
  assign s_o = p ^ {c3, c2, c1, c_i};
endmodule

module cla_sub #(
  parameter int N = 36
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         carry_o
);
  localparam int SLICES = N / 4;

  logic [SLICES:0] carry;
  logic [N-1:0]    b_n;

  assign b_n      = ~b_i;
  assign carry[0] = 1'b1;
  assign carry_o  = carry[SLICES];

  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    cla4 u_cla4 (
      .a_i (a_i[4*i +: 4]),
      .b_i (b_n[4*i +: 4]),
      .c_i (carry[i]),
      .s_o (diff_o[4*i +: 4]),
      .c_o (carry[i+1])
    );
  end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, registered results.
// WIDTH must be a multiple of 4 so the subtractor splits evenly into 4-bit cells.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             op_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                CW           = count_width(WIDTH);
  localparam int                SW           = WIDTH + 4;
  localparam logic [WIDTH-1:0]  DBZ_QUOTIENT = '1;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [SW-1:0]    trial_a, trial_b, diff_w;
  logic             cout_w, borrow_w, last_step;
  logic [WIDTH-1:0] r_next_w, q_next_w;
  logic             unused_diff_hi;

  // The partial remainder keeps every bit of R plus the incoming quotient bit (WIDTH+1 bits).
  assign trial_a   = {3'b000, r_q, q_q[WIDTH-1]};
  assign trial_b   = {4'b0000, dvsr_q};
  assign borrow_w  = ~cout_w;
  assign r_next_w  = borrow_w ? trial_a[WIDTH-1:0] : diff_w[WIDTH-1:0];
  assign q_next_w  = {q_q[WIDTH-2:0], ~borrow_w};
  assign last_step = (count_q == CW'(WIDTH - 1));
  assign unused_diff_hi = ^diff_w[SW-1:WIDTH];

  cla_sub #(.N(SW)) u_sub (
    .a_i     (trial_a),
    .b_i     (trial_b),
    .diff_o  (diff_w),
    .carry_o (cout_w)
  );

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default assignment first means no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (op_start) state_d = (divisor == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    op_done = (state_q == ST_DONE);
  end

  always_comb begin
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (op_start) begin
          count_d = '0;
          r_d     = '0;
          q_d     = dividend;
          dvsr_d  = divisor;
          if (divisor == '0) begin
            quot_d = DBZ_QUOTIENT;
            rem_d  = dividend;
            dbz_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        count_d = count_q + CW'(1);
        r_d     = r_next_w;
        q_d     = q_next_w;
        if (last_step) begin
          quot_d = q_next_w;
          rem_d  = r_next_w;
          dbz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
